d_reg_pipe: RTL and testbench
=============================

// Module: d_reg_pipe
// PURPOSE
//  - Parametrised WIDTH-bit, DEPTH-stage D-register pipeline; successor to the single-bit D latch.
//  - Adds per-stage valid bits, valid/ready handshake, bubble collapse and synchronous flush.
//  - Used as a retiming or elastic stage between sequential blocks; all storage is edge-triggered.
// PARAMETERS
//  - WIDTH  8  data bits per stage (>=1)
//  - DEPTH  4  number of register stages (>=1)
//  - CW     $clog2(DEPTH+1)  occupancy counter width (derived; not overridden)
// PORTS
//  - clk       in   1      rising-edge clock; the block's only clock
//  - rst_n     in   1      asynchronous, active-low reset
//  - flush     in   1      synchronous clear of all valid bits
//  - in_vld    in   1      input word valid
//  - in_rdy    out  1      pipeline can accept a word this cycle
//  - in_d      in   WIDTH  input data
//  - out_vld   out  1      last stage holds a valid word
//  - out_rdy   in   1      downstream accepts the word
//  - out_q     out  WIDTH  last-stage data
//  - cnt       out  CW     number of valid stages (0..DEPTH)
//  - out_perr  out  1      parity error on out_q (D_PIPE_PARITY_EN only)
//  - perr_inj  in   1      invert stored parity of the word entering stage 0 (D_PIPE_PARITY_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valids=0, data=0, cnt=0. Outputs: out_vld=0, out_q=0, in_rdy=1, out_perr=0.
//  - Stage i holds vld[i] and dat[i]; stage DEPTH-1 drives out_vld/out_q directly (registered outputs).
//  - adv[DEPTH-1] = !vld[DEPTH-1] | out_rdy; adv[i] = !vld[i] | adv[i+1]; in_rdy = adv[0] (combinational chain).
//  - On each clk edge, for each stage with adv[i]=1: vld[i] <= vld[i-1] and dat[i] <= dat[i-1]; stage 0 takes in_vld & in_rdy, in_d.
//  - Stages with adv[i]=0 hold. Bubbles collapse: upstream words move into empty stages while the output is stalled.
//  - Data registers load only when the incoming valid is 1; data of invalid stages is don't-care but never X after reset.
//  - Latency: with out_rdy=1 held, a word accepted at edge n appears on out_q after edge n+DEPTH-1 (DEPTH cycles in flight).
//  - Throughput: 1 word/cycle when out_rdy=1; no word is dropped or duplicated.
//  - Transfer rules: in: in_vld & in_rdy. out: out_vld & out_rdy. in_d is sampled only on an input transfer.
//  - Full (cnt=DEPTH) with out_rdy=0: in_rdy=0 and all stages hold.
//  - Full with out_rdy=1: in_rdy=1 in the same cycle (pass-through), and cnt stays DEPTH if in_vld=1.
//  - Empty: out_vld=0; out_rdy is ignored.
//  - cnt <= cnt + in_xfer - out_xfer; it never wraps (asserted 0..DEPTH).
//  - flush=1 at an edge: all vld <= 0 and cnt <= 0; a simultaneous input transfer is discarded (flush wins).
//  - in_rdy remains combinational during flush. Data registers are not cleared by flush.
//  - rst_n asserted mid-stream: immediate clear. The first edge after deassertion behaves as empty-pipe operation.
// CONFIGURATION
//  - Macro D_PIPE_PARITY_EN defined: each stage stores a parity bit, p0 = ^in_d ^ perr_inj.
//  - Parity advances with the data. out_perr = out_vld & (^out_q != p[DEPTH-1]), combinational from registers.
//  - Macro D_PIPE_PARITY_EN undefined: no parity storage. out_perr is tied to 0 and perr_inj is left unconnected.
//  - Ports exist in both builds.
// STRUCTURE
//  - Package d_pipe_pkg: localparam function for CW, stage-index typedef, reset data constant.
//  - Sub-module d_pipe_stage: one vld/dat(/parity) register with adv/load inputs, instantiated DEPTH times via generate.
//  - Top level: ready chain, occupancy counter and output mapping.
// TESTING (WIDTH=8, DEPTH=4)
//  - Reset: rst_n=0 at any time -> out_vld=0, out_q=0x00, cnt=0, in_rdy=1 asynchronously.
//  - Streaming: out_rdy=1, push 0x11,0x22,0x33 back-to-back -> 0x11 on out_q 3 edges after its accept, then 0x22, 0x33 consecutive.
//  - Stall/fill: out_rdy=0, push 0xA0..0xA5 -> 0xA0..0xA3 accepted, cnt=4, in_rdy=0.
//    Then out_rdy=1 -> 0xA0,A1,A2,A3,A4,A5 in order, no loss.
//  - Bubble collapse: push 0x01, idle 2 cycles, push 0x02, out_rdy=0 -> after 4 edges cnt=2 and both words are adjacent in the last two stages.
//  - Flush: cnt=3 plus flush=1 with in_vld=1 (0x55) -> next cycle cnt=0, out_vld=0; 0x55 never emerges.
//  - Parity (D_PIPE_PARITY_EN): push 0x0F with perr_inj=1 -> out_perr=1 exactly while 0x0F is on out_q with out_vld=1; 0 otherwise.

Source files
------------

// File: rtl/d_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : d_pipe_pkg
// Brief  : Shared types, constants and sizing helper for the d_reg_pipe slice.
// Rev    : 1.0  initial release
// ============================================================================
package d_pipe_pkg;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    typedef int unsigned stage_idx_t;

    localparam logic c_rst_bit = 1'b0;

endpackage : d_pipe_pkg
`default_nettype wire

// File: rtl/d_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module : d_pipe_stage
// Brief  : One pipeline register: valid bit, data word and optional parity bit.
// Rev    : 1.0  initial release
// ============================================================================
module d_pipe_stage
    import d_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit PAR_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             adv,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] dat_in,
    input  logic             par_in,
    output logic             vld,
    output logic [WIDTH-1:0] dat,
    output logic             par
);

    logic             r_vld;
    logic [WIDTH-1:0] r_dat;
    logic             w_load;

    // Data only moves with a valid word, so invalid stages keep stale payload.
    assign w_load = adv & vld_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= {WIDTH{c_rst_bit}};
        end else begin
            if (flush) begin
                r_vld <= 1'b0;
            end else if (adv) begin
                r_vld <= vld_in;
            end
            if (w_load) begin
                r_dat <= dat_in;
            end
        end
    end

    assign vld = r_vld;
    assign dat = r_dat;

    generate
        if (PAR_EN) begin : g_par
            logic r_par;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_par <= c_rst_bit;
                end else if (w_load) begin
                    r_par <= par_in;
                end
            end
            assign par = r_par;
        end else begin : g_nopar
            logic w_unused_par;
            assign w_unused_par = par_in;
            assign par          = 1'b0;
        end
    endgenerate

endmodule : d_pipe_stage
`default_nettype wire

// File: rtl/d_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module : d_reg_pipe
// Brief  : WIDTH x DEPTH elastic register pipeline with valid/ready handshake,
//          bubble collapse, synchronous flush and occupancy count.
//          Optional parity path enabled by defining D_PIPE_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
module d_reg_pipe
    import d_pipe_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_d,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_q,
    output logic [CW-1:0]    cnt,
    output logic             out_perr,
    input  logic             perr_inj
);

`ifdef D_PIPE_PARITY_EN
    localparam bit c_par_en = 1'b1;
`else
    localparam bit c_par_en = 1'b0;
`endif

    logic [DEPTH-1:0] w_vld;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_par;
    logic [WIDTH-1:0] w_dat [DEPTH];
    logic             w_par0;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CW-1:0]    r_cnt;

    // A stage may advance when it is empty or everything downstream advances.
    always_comb begin
        w_adv            = '0;
        w_adv[DEPTH-1]   = ~w_vld[DEPTH-1] | out_rdy;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = ~w_vld[i] | w_adv[i+1];
        end
    end

    assign in_rdy     = w_adv[0];
    assign w_in_xfer  = in_vld & in_rdy;
    assign w_out_xfer = w_vld[DEPTH-1] & out_rdy;

`ifdef D_PIPE_PARITY_EN
    assign w_par0   = (^in_d) ^ perr_inj;
    assign out_perr = w_vld[DEPTH-1] & ((^w_dat[DEPTH-1]) != w_par[DEPTH-1]);
`else
    logic w_unused;
    assign w_par0   = 1'b0;
    assign out_perr = 1'b0;
    assign w_unused = ^{perr_inj, w_par};
`endif

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             w_src_vld;
            logic [WIDTH-1:0] w_src_dat;
            logic             w_src_par;

            if (i == 0) begin : g_head
                assign w_src_vld = in_vld;
                assign w_src_dat = in_d;
                assign w_src_par = w_par0;
            end else begin : g_body
                assign w_src_vld = w_vld[i-1];
                assign w_src_dat = w_dat[i-1];
                assign w_src_par = w_par[i-1];
            end

            d_pipe_stage #(
                .WIDTH  (WIDTH),
                .PAR_EN (c_par_en)
            ) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .flush  (flush),
                .adv    (w_adv[i]),
                .vld_in (w_src_vld),
                .dat_in (w_src_dat),
                .par_in (w_src_par),
                .vld    (w_vld[i]),
                .dat    (w_dat[i]),
                .par    (w_par[i])
            );
        end
    endgenerate

    // Flush discards any same-edge input transfer, so it simply zeroes the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(w_in_xfer) - CW'(w_out_xfer);
        end
    end

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= CW'(DEPTH));

    assign cnt     = r_cnt;
    assign out_vld = w_vld[DEPTH-1];
    assign out_q   = w_dat[DEPTH-1];

endmodule : d_reg_pipe
`default_nettype wire

// File: tb/tb_d_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_d_reg_pipe
// Brief  : Scoreboard bench for d_reg_pipe (WIDTH=8, DEPTH=4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_d_reg_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef D_PIPE_PARITY_EN
    localparam bit c_par = 1'b1;
`else
    localparam bit c_par = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             inj;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_d;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] out_q;
    logic [CW-1:0]    cnt;
    logic             out_perr;
    logic             perr_inj;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_pops  = 0;

    d_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_d     (in_d),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_q    (out_q),
        .cnt      (cnt),
        .out_perr (out_perr),
        .perr_inj (perr_inj)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the word on in_d until it is accepted, bounded.
    task automatic push(input logic [WIDTH-1:0] d);
        in_vld = 1'b1;
        in_d   = d;
        for (int k = 0; k < 64; k++) begin
            if (in_rdy) begin
                step();
                in_vld = 1'b0;
                return;
            end
            step();
        end
        chk("push_accept", {31'd0, in_rdy}, 32'd1);
        in_vld = 1'b0;
    endtask

    always @(negedge rst_n) q.delete();

    // Monitor: compares against the queue model, then applies the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("cnt", 32'(cnt), 32'(q.size()));
            chk("in_rdy", {31'd0, in_rdy}, {31'd0, (q.size() < DEPTH) || out_rdy});
            if (q.size() == 0) begin
                chk("out_vld_empty", {31'd0, out_vld}, 32'd0);
                chk("out_perr_idle", {31'd0, out_perr}, 32'd0);
            end else if (out_vld) begin
                chk("out_q", 32'(out_q), 32'(q[0].d));
                chk("out_perr", {31'd0, out_perr}, {31'd0, c_par && q[0].inj});
            end
            if (out_vld && out_rdy && q.size() > 0) begin
                void'(q.pop_front());
                n_pops++;
            end
            if (flush) q.delete();
            else if (in_vld && in_rdy) q.push_back('{in_d, perr_inj});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; in_d = '0; out_rdy = 1'b0; perr_inj = 1'b0;
        #3;
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_out_q",   32'(out_q), 32'd0);
        chk("rst_cnt",     32'(cnt), 32'd0);
        chk("rst_in_rdy",  {31'd0, in_rdy}, 32'd1);
        chk("rst_perr",    {31'd0, out_perr}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Streaming with DEPTH-1 edge latency after accept.
        out_rdy = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        step(); chk("stream_v0", {31'd0, out_vld}, 32'd1); chk("stream_q0", 32'(out_q), 32'h11);
        step(); chk("stream_v1", {31'd0, out_vld}, 32'd1); chk("stream_q1", 32'(out_q), 32'h22);
        step(); chk("stream_v2", {31'd0, out_vld}, 32'd1); chk("stream_q2", 32'(out_q), 32'h33);
        step(); chk("stream_end", {31'd0, out_vld}, 32'd0);

        // Stall/fill then drain.
        out_rdy = 1'b0;
        p0 = n_pops;
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        in_vld = 1'b1; in_d = 8'hA4;
        step(); step();
        chk("full_cnt", 32'(cnt), 32'd4);
        chk("full_in_rdy", {31'd0, in_rdy}, 32'd0);
        chk("full_out_q", 32'(out_q), 32'hA0);
        out_rdy = 1'b1;
        #1;
        chk("full_passthru_rdy", {31'd0, in_rdy}, 32'd1);
        push(8'hA4); push(8'hA5);
        repeat (6) step();
        chk("stall_drained", {31'd0, out_vld}, 32'd0);
        chk("stall_pops", 32'(n_pops - p0), 32'd6);

        // Bubble collapse.
        out_rdy = 1'b0;
        push(8'h01); step(); step(); push(8'h02);
        repeat (4) step();
        chk("bubble_cnt", 32'(cnt), 32'd2);
        chk("bubble_q0", 32'(out_q), 32'h01);
        out_rdy = 1'b1;
        step();
        chk("bubble_adj_v", {31'd0, out_vld}, 32'd1);
        chk("bubble_adj_q", 32'(out_q), 32'h02);
        step();
        chk("bubble_end", {31'd0, out_vld}, 32'd0);

        // Flush beats a simultaneous input transfer.
        out_rdy = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3);
        step();
        chk("preflush_cnt", 32'(cnt), 32'd3);
        flush = 1'b1; in_vld = 1'b1; in_d = 8'h55;
        step();
        flush = 1'b0; in_vld = 1'b0;
        chk("flush_cnt", 32'(cnt), 32'd0);
        chk("flush_vld", {31'd0, out_vld}, 32'd0);
        out_rdy = 1'b1;
        repeat (8) begin
            step();
            chk("flush_no55", {31'd0, out_vld}, 32'd0);
        end

`ifdef D_PIPE_PARITY_EN
        perr_inj = 1'b1;
        push(8'h0F);
        perr_inj = 1'b0;
        step(); step(); step();
        chk("par_q", 32'(out_q), 32'h0F);
        chk("par_err", {31'd0, out_perr}, 32'd1);
        step();
        chk("par_clear", {31'd0, out_perr}, 32'd0);
`endif

        // Asynchronous reset in mid-stream.
        out_rdy = 1'b0;
        push(8'hE1); push(8'hE2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, out_vld}, 32'd0);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        chk("mid_rst_rdy", {31'd0, in_rdy}, 32'd1);
        chk("mid_rst_q",   32'(out_q), 32'd0);
        #1 rst_n = 1'b1;
        step();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            in_vld   = ($urandom_range(0, 9) < 7);
            in_d     = 8'($urandom);
            out_rdy  = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 49) == 0);
            perr_inj = c_par && ($urandom_range(0, 9) == 0);
            step();
        end
        in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b1; perr_inj = 1'b0;
        repeat (DEPTH + 2) step();
        chk("final_model_empty", 32'(q.size()), 32'd0);
        chk("final_out_vld", {31'd0, out_vld}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_d_reg_pipe
`default_nettype wire
